unidade_controle: RTL

Control sequencer for the 4-bit CPU datapath. It accepts one instruction at a time over a valid/ready handshake and drives the per-register control codes `tx`, `ty`, `tz` and `tula` that the X (bus), Y (accumulator) and Z (output) registers decode. It also drives the immediate operand onto X's `entrada`. Multi-step instructions (load-and-add, repeated add) are sequenced internally.

---
 rtl/cpu_pkg.sv | 42 ++++
 rtl/unidade_controle_decod_passo.sv | 36 +++
 rtl/unidade_controle.sv | 126 ++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the 4-bit CPU: register control codes, ALU selects,
// opcodes and controller states.
package cpu_pkg;

    localparam logic [3:0] CLEAR  = 4'd0;
    localparam logic [3:0] LOAD   = 4'd1;
    localparam logic [3:0] HOLD   = 4'd2;
    localparam logic [3:0] SHIFTR = 4'd3;

    localparam logic [3:0] TULA_SOMA = 4'h0;
    localparam logic [3:0] TULA_NADA = 4'hF;

    typedef enum logic [2:0] {
        OP_NOP    = 3'd0,
        OP_CLR    = 3'd1,
        OP_LDX    = 3'd2,
        OP_ADD    = 3'd3,
        OP_SHR    = 3'd4,
        OP_STZ    = 3'd5,
        OP_LDADD  = 3'd6,
        OP_REPADD = 3'd7
    } opcode_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXEC   = 2'd1,
        EXEC2  = 2'd2,
        REPETE = 2'd3
    } estado_t;

    typedef struct packed {
        logic [3:0] tx;
        logic [3:0] ty;
        logic [3:0] tz;
        logic [3:0] tula;
    } ctrl_t;

    localparam ctrl_t CTRL_OCIOSO = {HOLD, HOLD, HOLD, TULA_NADA};
    localparam ctrl_t CTRL_SOMA   = {HOLD, LOAD, HOLD, TULA_SOMA};
    localparam ctrl_t CTRL_LDX    = {LOAD, HOLD, HOLD, TULA_NADA};

endpackage

// File: rtl/unidade_controle_decod_passo.sv
// Combinational map from (step state, opcode) to the register and ALU control
// codes driven during that step.
module decod_passo
    import cpu_pkg::*;
(
    input  estado_t passo,
    input  opcode_t opcode,
    input  logic    arg_zero,
    output ctrl_t   ctrl
);

    always_comb begin
        ctrl = CTRL_OCIOSO;
        unique case (passo)
            IDLE: ctrl = CTRL_OCIOSO;
            EXEC: begin
                unique case (opcode)
                    OP_NOP:    ctrl = CTRL_OCIOSO;
                    OP_CLR:    ctrl = {CLEAR, CLEAR, CLEAR, TULA_NADA};
                    OP_LDX:    ctrl = CTRL_LDX;
                    OP_ADD:    ctrl = CTRL_SOMA;
                    OP_SHR:    ctrl = {HOLD, SHIFTR, HOLD, TULA_NADA};
                    OP_STZ:    ctrl = {HOLD, HOLD, LOAD, TULA_NADA};
                    OP_LDADD:  ctrl = CTRL_LDX;
                    // A zero repeat count degenerates to a single idle step.
                    OP_REPADD: ctrl = arg_zero ? CTRL_OCIOSO : CTRL_SOMA;
                    default:   ctrl = CTRL_OCIOSO;
                endcase
            end
            EXEC2:   ctrl = CTRL_SOMA;
            REPETE:  ctrl = CTRL_SOMA;
            default: ctrl = CTRL_OCIOSO;
        endcase
    end

endmodule

// File: rtl/unidade_controle.sv
// Instruction sequencer: accepts one instruction over valid/ready and drives
// registered per-step control codes for the X, Y and Z registers and the ALU.
module unidade_controle
    import cpu_pkg::*;
#(
    parameter int W_DADO = 4,
    parameter int W_CONT = 4
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic [6:0]        instr,
    input  logic              instr_valid,
    output logic              instr_ready,
    output logic [W_DADO-1:0] dado_x,
    output logic [3:0]        tx,
    output logic [3:0]        ty,
    output logic [3:0]        tz,
    output logic [3:0]        tula,
    output logic              ocupado,
    output logic              fim
);

    localparam logic [W_CONT-1:0] CONT_UM   = W_CONT'(1);
    localparam logic [W_CONT-1:0] CONT_DOIS = W_CONT'(2);

    estado_t             estado_q, estado_d;
    opcode_t             op_q, op_d;
    logic [W_DADO-1:0]   dado_q, dado_d;
    logic [W_CONT-1:0]   cont_q, cont_d;
    ctrl_t               ctrl_q, ctrl_d;
    logic                fim_q, fim_d;
    logic                ocupado_q;
    logic                ready_q;

    opcode_t             op_in;
    logic [W_CONT-1:0]   arg_cont;
    logic                aceita;

    assign op_in    = opcode_t'(instr[6:4]);
    assign arg_cont = W_CONT'(instr[3:0]);
    assign aceita   = instr_valid & ready_q;

    // Next-state logic; fim_d flags that the step being entered is the last.
    always_comb begin
        estado_d = estado_q;
        op_d     = op_q;
        dado_d   = dado_q;
        cont_d   = cont_q;
        fim_d    = 1'b0;
        unique case (estado_q)
            IDLE: begin
                if (aceita) begin
                    estado_d = EXEC;
                    op_d     = op_in;
                    dado_d   = W_DADO'(instr[3:0]);
                    cont_d   = arg_cont;
                    fim_d    = !((op_in == OP_LDADD) ||
                                 ((op_in == OP_REPADD) && (arg_cont > CONT_UM)));
                end
            end
            EXEC: begin
                if (op_q == OP_LDADD) begin
                    estado_d = EXEC2;
                    fim_d    = 1'b1;
                end else if ((op_q == OP_REPADD) && (cont_q > CONT_UM)) begin
                    estado_d = REPETE;
                    cont_d   = cont_q - CONT_UM;
                    fim_d    = (cont_q == CONT_DOIS);
                end else begin
                    estado_d = IDLE;
                end
            end
            EXEC2: estado_d = IDLE;
            REPETE: begin
                // The count is tested before decrementing, so it never wraps.
                if (cont_q > CONT_UM) begin
                    cont_d = cont_q - CONT_UM;
                    fim_d  = (cont_q == CONT_DOIS);
                end else begin
                    estado_d = IDLE;
                end
            end
            default: estado_d = IDLE;
        endcase
    end

    // Codes are decoded from the next state so they are valid for the whole step.
    decod_passo u_decod_passo (
        .passo    (estado_d),
        .opcode   (op_d),
        .arg_zero (cont_d == '0),
        .ctrl     (ctrl_d)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            estado_q  <= IDLE;
            op_q      <= OP_NOP;
            dado_q    <= '0;
            cont_q    <= '0;
            ctrl_q    <= CTRL_OCIOSO;
            fim_q     <= 1'b0;
            ocupado_q <= 1'b0;
            ready_q   <= 1'b1;
        end else begin
            estado_q  <= estado_d;
            op_q      <= op_d;
            dado_q    <= dado_d;
            cont_q    <= cont_d;
            ctrl_q    <= ctrl_d;
            fim_q     <= fim_d;
            ocupado_q <= (estado_d != IDLE);
            ready_q   <= (estado_d == IDLE);
        end
    end

    assign instr_ready = ready_q;
    assign dado_x      = dado_q;
    assign tx          = ctrl_q.tx;
    assign ty          = ctrl_q.ty;
    assign tz          = ctrl_q.tz;
    assign tula        = ctrl_q.tula;
    assign ocupado     = ocupado_q;
    assign fim         = fim_q;

endmodule
